cmd_sequencer: RTL
==================

Name: cmd_sequencer

Overview:
- Top-level command sequencer for the cache controller.
- Accepts one host command at a time over a valid/ready handshake and decodes it as GET, PUT or DEL.
- Launches the matching sub-FSM (get/put/del) with a one-cycle enter pulse, then holds that sub-FSM's enable until it reports done or a timeout expires.
- Returns a status response over a second valid/ready handshake. It is the only agent driving sub-FSM enter/en.

Parameters:
- KEY_W, 32, key width in bits.
- VAL_W, 64, value width in bits.
- TIMEOUT_CYCLES, 16, maximum RUN cycles before abort (must be >=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  host command valid
- req_ready  out  1  sequencer can accept a command
- req_op  in  2  00 GET, 01 PUT, 10 DEL, 11 illegal
- req_key  in  KEY_W  command key
- req_value  in  VAL_W  command value (PUT only)
- op_key  out  KEY_W  latched key to datapath
- op_value  out  VAL_W  latched value to datapath
- sub_enter  out  3  one-hot enter pulse: [0] get, [1] put, [2] del
- sub_en  out  3  one-hot enable to the active sub-FSM
- sub_done  in  3  per-sub-FSM completion, level sampled
- sub_err  in  3  per-sub-FSM error/miss, valid with sub_done
- abort  out  1  one-cycle pulse on timeout
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_op  out  2  op code of the completed command
- rsp_status  out  2  00 OK, 01 ERR/MISS, 10 TIMEOUT, 11 ILLEGAL
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - All outputs 0 except req_ready = 1.
  - op_key, op_value, rsp_op, rsp_status and the timeout counter = 0.
- State machine: IDLE, DISPATCH, RUN, RESP.
- IDLE:
  - req_ready = 1.
  - When req_valid is high, capture req_op, req_key and req_value into registers; op_key/op_value update the next edge.
  - Legal op -> DISPATCH.
  - op 11 -> RESP with rsp_status = 11 and rsp_op = 11; no sub-FSM is touched.
- DISPATCH (exactly 1 cycle):
  - sub_enter[op] = 1; sub_en = 0.
  - Counter cleared to 0.
  - sub_done is ignored in this state.
  - -> RUN.
- RUN:
  - sub_en[op] = 1; all other bits 0.
  - Each cycle, sample sub_done[op]:
    - If 1: go to RESP, with rsp_status = sub_err[op] ? 01 : 00.
    - Else if counter == TIMEOUT_CYCLES-1: go to RESP with rsp_status = 10, and assert abort for that cycle.
    - Else: counter increments.
  - If done and timeout fall on the same cycle, done wins (no abort).
  - sub_done/sub_err bits of non-selected sub-FSMs are ignored.
- RESP:
  - rsp_valid = 1; rsp_op and rsp_status held stable.
  - sub_en = 0.
  - -> IDLE on the cycle rsp_ready = 1.
  - rsp_valid rises only after registered transition into RESP (no combinational path from sub_done).
- req_ready = 1 only in IDLE. A new request cannot be accepted in the same cycle a response completes; it is accepted the following cycle.
- Counter width is $clog2(TIMEOUT_CYCLES). It never wraps, because RUN exits at TIMEOUT_CYCLES-1.
- Latency for a legal op:
  - Accept at cycle t.
  - sub_enter at t+1.
  - sub_en from t+2.
  - If done is seen at cycle d, rsp_valid is high from d+1.
- sub_enter and sub_en are never both non-zero. At most one bit of each is set.
- op_key/op_value hold their values until the next accepted request.
- Reset mid-operation: immediate return to IDLE. sub_en and sub_enter drop asynchronously, and no response is issued.

Test Plan:
- GET OK: req_op=00, key=0xA5, accepted at cycle 0; sub_done[0]=1, sub_err[0]=0 at cycle 5 -> sub_enter=001 at cycle 1, sub_en=001 over cycles 2-5, rsp_valid at cycle 6 with status 00, op 00, op_key=0xA5.
- PUT error plus backpressure: req_op=01, sub_done[1]=sub_err[1]=1 after 3 RUN cycles, rsp_ready low for 4 cycles -> rsp_valid held 4+ cycles with status 01 stable; req_ready=0 until the cycle after the rsp_ready handshake.
- DEL timeout (TIMEOUT_CYCLES=8): sub_done never asserted -> sub_en=100 for exactly 8 cycles, abort pulses on the 8th RUN cycle, rsp_status=10.
- Done/timeout collision: sub_done[2]=1 on the 8th RUN cycle -> status 00/01 per sub_err, abort stays 0.
- Illegal op 11 -> sub_enter and sub_en remain 000; rsp_valid on the cycle after accept with status 11.
- Stray done plus reset: sub_done[1]=1 during a GET RUN -> ignored, still waiting on sub_done[0]. Then rst_n low mid-RUN -> sub_en=000, busy=0, req_ready=1 immediately, and no rsp_valid.

Source files
------------

// File: rtl/cmd_sequencer.sv
// Cache-controller command sequencer: accepts one host command, launches the
// matching get/put/del sub-FSM, guards it with a timeout and returns a status.
module cmd_sequencer #(
   parameter int KEY_W          = 32,
   parameter int VAL_W          = 64,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [KEY_W-1:0] req_key,
   input  logic [VAL_W-1:0] req_value,
   output logic [KEY_W-1:0] op_key,
   output logic [VAL_W-1:0] op_value,
   output logic [2:0]       sub_enter,
   output logic [2:0]       sub_en,
   input  logic [2:0]       sub_done,
   input  logic [2:0]       sub_err,
   output logic             abort,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [1:0]       rsp_op,
   output logic [1:0]       rsp_status,
   output logic             busy
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DISPATCH, RUN, RESP} state_t;

   state_t          state;
   logic [2:0]      sel;
   logic [2:0]      dec;
   logic [CW-1:0]   cnt;
   logic            hit;
   logic            hit_err;

   always_comb begin
      dec = 3'b000;
      unique case (req_op)
         2'b00:   dec = 3'b001;
         2'b01:   dec = 3'b010;
         2'b10:   dec = 3'b100;
         default: dec = 3'b000;
      endcase
   end

   // Only the selected sub-FSM's done/err bits matter.
   assign hit     = |(sub_done & sel);
   assign hit_err = |(sub_err & sel);
   assign abort   = (state == RUN) && !hit && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sel        <= 3'b000;
         cnt        <= '0;
         op_key     <= '0;
         op_value   <= '0;
         rsp_op     <= 2'b00;
         rsp_status <= 2'b00;
         sub_enter  <= 3'b000;
         sub_en     <= 3'b000;
         rsp_valid  <= 1'b0;
         req_ready  <= 1'b1;
         busy       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  op_key    <= req_key;
                  op_value  <= req_value;
                  sel       <= dec;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (dec == 3'b000) begin
                     state      <= RESP;
                     rsp_op     <= 2'b11;
                     rsp_status <= 2'b11;
                     rsp_valid  <= 1'b1;
                  end else begin
                     state     <= DISPATCH;
                     rsp_op    <= req_op;
                     sub_enter <= dec;
                  end
               end
            end
            DISPATCH: begin
               sub_enter <= 3'b000;
               sub_en    <= sel;
               cnt       <= '0;
               state     <= RUN;
            end
            RUN: begin
               if (hit) begin
                  state      <= RESP;
                  sub_en     <= 3'b000;
                  rsp_valid  <= 1'b1;
                  rsp_status <= hit_err ? 2'b01 : 2'b00;
               end else if (cnt == LAST) begin
                  state      <= RESP;
                  sub_en     <= 3'b000;
                  rsp_valid  <= 1'b1;
                  rsp_status <= 2'b10;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
